// File: rtl/dm_arb_pkg.sv
// Shared definitions for the data-memory arbiter: requester ids and the
// round-robin winner rule used when both requesters collide.
package dm_arb_pkg;

    typedef enum logic {
        REQ_CORE = 1'b0,
        REQ_HOST = 1'b1
    } req_id_e;

    // Winner of a simultaneous request: host while halted, otherwise whoever was not last.
    function automatic req_id_e rr_winner(input logic halted, input req_id_e last);
        req_id_e win;
        if (halted) begin
            win = REQ_HOST;
        end else if (last == REQ_HOST) begin
            win = REQ_CORE;
        end else begin
            win = REQ_HOST;
        end
        return win;
    endfunction

endpackage

// File: rtl/dm_arb_rport.sv
// Per-requester read return: one-cycle rvalid pulse and a hold register that
// keeps the last read value stable until that requester's next read completes.
module dm_arb_rport #(
    parameter int DW = 16
) (
    input  logic          clk_i,
    input  logic          rst_n_i,
    input  logic          pend_i,
    input  logic [DW-1:0] m_rdata_i,
    output logic          rvalid_o,
    output logic [DW-1:0] rdata_o
);

    logic [DW-1:0] hold_q;
    logic [DW-1:0] hold_d;

    // Read-data steering and hold capture; reset suppresses an in-flight return.
    always_comb begin
        rvalid_o = rst_n_i & pend_i;
        hold_d   = hold_q;
        if (rvalid_o) begin
            hold_d = m_rdata_i;
        end else begin
            hold_d = hold_q;
        end
        if (!rst_n_i) begin
            rdata_o = {DW{1'b0}};
        end else if (rvalid_o) begin
            rdata_o = m_rdata_i;
        end else begin
            rdata_o = hold_q;
        end
    end

    // Hold register.
    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            hold_q <= {DW{1'b0}};
        end else begin
            hold_q <= hold_d;
        end
    end

endmodule

// File: rtl/dm_arb.sv
// Single-port data-memory arbiter between the core and a host port: zero-latency
// grant, round-robin on conflict (host wins while halted), 1-cycle read return.
module dm_arb
    import dm_arb_pkg::*;
#(
    parameter int DW = 16,
    parameter int AW = 8
) (
    input  logic          clk_i,
    input  logic          rst_n_i,
    input  logic          halted_i,
    input  logic          c_req_i,
    input  logic          c_we_i,
    input  logic [AW-1:0] c_addr_i,
    input  logic [DW-1:0] c_wdata_i,
    output logic          c_gnt_o,
    output logic          c_stall_o,
    output logic          c_rvalid_o,
    output logic [DW-1:0] c_rdata_o,
    input  logic          h_req_i,
    input  logic          h_we_i,
    input  logic [AW-1:0] h_addr_i,
    input  logic [DW-1:0] h_wdata_i,
    output logic          h_gnt_o,
    output logic          h_rvalid_o,
    output logic [DW-1:0] h_rdata_o,
    output logic          m_en_o,
    output logic          m_we_o,
    output logic [AW-1:0] m_addr_o,
    output logic [DW-1:0] m_wdata_o,
    input  logic [DW-1:0] m_rdata_i
);

    req_id_e last_q;
    req_id_e last_d;
    req_id_e rv_own_q;
    req_id_e rv_own_d;
    logic    rv_pend_q;
    logic    rv_pend_d;
    logic    c_gnt_s;
    logic    h_gnt_s;
    logic    rd_issue_s;

    // Grant decision; nothing is granted while reset is held.
    always_comb begin
        c_gnt_s = 1'b0;
        h_gnt_s = 1'b0;
        if (!rst_n_i) begin
            c_gnt_s = 1'b0;
            h_gnt_s = 1'b0;
        end else begin
            case ({c_req_i, h_req_i})
                2'b11: begin
                    if (rr_winner(halted_i, last_q) == REQ_HOST) begin
                        h_gnt_s = 1'b1;
                    end else begin
                        c_gnt_s = 1'b1;
                    end
                end
                2'b10:   c_gnt_s = 1'b1;
                2'b01:   h_gnt_s = 1'b1;
                default: begin
                    c_gnt_s = 1'b0;
                    h_gnt_s = 1'b0;
                end
            endcase
        end
    end

    // Memory port mux and next-state for round-robin and read ownership.
    always_comb begin
        m_en_o     = c_gnt_s | h_gnt_s;
        m_we_o     = 1'b0;
        m_addr_o   = c_addr_i;
        m_wdata_o  = c_wdata_i;
        if (h_gnt_s) begin
            m_we_o    = h_we_i;
            m_addr_o  = h_addr_i;
            m_wdata_o = h_wdata_i;
        end else begin
            m_we_o    = c_gnt_s & c_we_i;
            m_addr_o  = c_addr_i;
            m_wdata_o = c_wdata_i;
        end
        rd_issue_s = m_en_o & ~m_we_o;
        rv_pend_d  = rd_issue_s;
        if (h_gnt_s) begin
            last_d = REQ_HOST;
        end else if (c_gnt_s) begin
            last_d = REQ_CORE;
        end else begin
            last_d = last_q;
        end
        if (rd_issue_s) begin
            rv_own_d = h_gnt_s ? REQ_HOST : REQ_CORE;
        end else begin
            rv_own_d = rv_own_q;
        end
    end

    // Arbiter state registers.
    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            last_q    <= REQ_HOST;
            rv_pend_q <= 1'b0;
            rv_own_q  <= REQ_CORE;
        end else begin
            last_q    <= last_d;
            rv_pend_q <= rv_pend_d;
            rv_own_q  <= rv_own_d;
        end
    end

    assign c_gnt_o   = c_gnt_s;
    assign h_gnt_o   = h_gnt_s;
    assign c_stall_o = c_req_i & ~c_gnt_s & rst_n_i;

    dm_arb_rport #(.DW(DW)) u_core_rport (
        .clk_i     (clk_i),
        .rst_n_i   (rst_n_i),
        .pend_i    (rv_pend_q & (rv_own_q == REQ_CORE)),
        .m_rdata_i (m_rdata_i),
        .rvalid_o  (c_rvalid_o),
        .rdata_o   (c_rdata_o)
    );

    dm_arb_rport #(.DW(DW)) u_host_rport (
        .clk_i     (clk_i),
        .rst_n_i   (rst_n_i),
        .pend_i    (rv_pend_q & (rv_own_q == REQ_HOST)),
        .m_rdata_i (m_rdata_i),
        .rvalid_o  (h_rvalid_o),
        .rdata_o   (h_rdata_o)
    );

endmodule

// File: doc/dm_arb.md
# dm_arb

Data-memory arbiter that shares the processor's single-port, synchronous-read data memory between the pu core and a host port (program loader or debug). It sits between the core's memory-access signals (driven by `dmwe`/`dms` from the decoder) and the memory macro. Every cycle it grants at most one requester and routes the 1-cycle-latency read data back to its owner. While the core waits for a grant, the arbiter stalls it.

## Interface
Parameters:
- `DW`, 16, data width; matches the register and ALU width.
- `AW`, 8, data-memory address width. Requester addresses are truncated to `AW`.

Ports:
- `clk`  in  1  single clock; all state updates on the rising edge.
- `rst_n`  in  1  synchronous, active-low reset.
- `halted`  in  1  the core has executed HALT; while high, the host has absolute priority.
- `c_req`  in  1  core requests an access this cycle.
- `c_we`  in  1  core access is a write (1) or a read (0).
- `c_addr`  in  AW  core address.
- `c_wdata`  in  DW  core write data.
- `c_gnt`  out  1  core access is performed this cycle.
- `c_stall`  out  1  equals `c_req & ~c_gnt`; holds the PC and pipeline.
- `c_rvalid`  out  1  core read data is valid this cycle.
- `c_rdata`  out  DW  core read data.
- `h_req`, `h_we`, `h_addr`, `h_wdata`, `h_gnt`, `h_rvalid`, `h_rdata`: the same as the core signals, for the host.
- `m_en`  out  1  memory access strobe.
- `m_we`  out  1  memory write enable.
- `m_addr`  out  AW  memory address.
- `m_wdata`  out  DW  memory write data.
- `m_rdata`  in  DW  memory read data, valid the cycle after an `m_en & ~m_we` access.

## Operation
Grant rule (combinational, evaluated each cycle):
- No request: no grant, and `m_en` = 0.
- One requester active: that requester is granted.
- Both active and `halted` = 1: the host is granted.
- Both active and `halted` = 0: the requester that is not `last` is granted (round-robin).

State:
- `last` (1 bit, 0 = core, 1 = host): set to the granted requester's id on every grant. Reset value is host, so the core wins the first conflict.
- `rv_pend`, `rv_own`: record that a read was issued and which requester owns it. Next cycle, the owner's `*_rvalid` pulses for exactly one cycle.
- `c_rhold`, `h_rhold` (DW each): capture `m_rdata` on the owner's rvalid cycle. `*_rdata` is driven from `m_rdata` during the rvalid cycle and from the hold register afterwards. Each value stays stable until that requester's next read completes.

Memory port:
- `m_*` are muxed combinationally from the granted requester.
- Writes complete in the grant cycle and generate no rvalid.

Requester obligations:
- A requester keeps `req`, `we`, `addr` and `wdata` stable until it sees `gnt`.
- The core retries every cycle while stalled.

## Timing
- Grant latency is 0 cycles: `gnt` is asserted in the same cycle as `req` when that requester wins.
- Read latency is 1 cycle: a read granted in cycle N produces `*_rvalid` and `*_rdata` = `m_rdata` in cycle N+1.
- Throughput: back-to-back grants are allowed every cycle, to either requester.
- Worst-case core wait under continuous contention with `halted` = 0 is 1 cycle.
- Reset values: `last` = host, `rv_pend` = 0, `rv_own` = core, both hold registers = 0.
  - All `*_rvalid`, `*_gnt`, `c_stall` and `m_en` are 0 while `rst_n` = 0, regardless of requests.
- Reset asserted in the cycle after a granted read: the rvalid for that read is suppressed (`rv_pend` is cleared), and `*_rdata` reads 0.
- `halted` rising during contention takes effect in the same cycle.
- A read and a write to the same address in consecutive cycles: the read returns the memory contents at the time of its grant, with no forwarding. Write-then-read in the next cycle returns the new data.

## Structure
- Requester-id constants (`REQ_CORE` = 0, `REQ_HOST` = 1) go in the shared `pu.vh` header, next to `` `ASSERT``/`` `NEGATE``.
- One sub-module is natural: `dm_rport`, the per-requester read-data capture and hold register with its rvalid output. It is instantiated twice.
- The grant logic and `last` stay in `dm_arb`.

## Test plan
- **Single core read.** Memory[0x12] = 0xBEEF; `c_req` = 1, `c_we` = 0, `c_addr` = 0x12. Required: `c_gnt` = 1 and `c_stall` = 0 in the same cycle; next cycle `c_rvalid` = 1 and `c_rdata` = 0xBEEF; `c_rdata` still 0xBEEF 3 cycles later.
- **First conflict after reset.** Both requesters request a read. Required: the core is granted in cycle 0, the host in cycle 1, and `c_stall` = 0 in cycle 0.
- **Sustained conflict.** Both requesters request for 6 cycles with `halted` = 0. Required: grants alternate C, H, C, H, C, H, and each rvalid goes only to its owner.
- **Halted.** `halted` = 1 with both requesters active for 4 cycles. Required: `h_gnt` = 1 in every cycle, and `c_stall` = 1 throughout.
- **Host write then core read.** Host writes 0x0055 to address 0x03, then the core reads 0x03 in the next cycle. Required: `c_rdata` = 0x0055 with `c_rvalid` one cycle after the read grant.
- **Reset mid-read.** Core read granted in cycle N, `rst_n` = 0 in cycle N+1. Required: `c_rvalid` = 0, `c_rdata` = 0, and `last` = host after reset.
